// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: opcodes, instruction field positions and offset sign-extension
package simple_cpu_pkg;
  typedef enum logic [3:0] {
    OP_LD  = 4'd0,
    OP_ST  = 4'd1,
    OP_ADD = 4'd2,
    OP_LDI = 4'd3,
    OP_JMP = 4'd4,
    OP_BZ  = 4'd5,
    OP_SUB = 4'd6,
    OP_AND = 4'd7,
    OP_OR  = 4'd8,
    OP_XOR = 4'd9
  } opcode_e;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RA_MSB = 11;
  localparam int RA_LSB = 8;
  localparam int RB_MSB = 7;
  localparam int RB_LSB = 4;
  localparam int RC_MSB = 3;
  localparam int RC_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  function automatic logic [9:0] sext_off(input logic [7:0] imm);
    return {{2{imm[7]}}, imm};
  endfunction
endpackage

// File: rtl/simple_cpu_execunit.sv
// simple_cpu_execunit: decode, ALU, register bank and next-pc logic
module simple_cpu_regbank (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ra_i,
  input  logic [3:0]  rb_i,
  input  logic [3:0]  rc_i,
  input  logic        we_i,
  input  logic [15:0] wd_i,
  output logic [15:0] ra_o,
  output logic [15:0] rb_o,
  output logic [15:0] rc_o
);
  logic [15:0] mem [0:15];
  assign ra_o = mem[ra_i];
  assign rb_o = mem[rb_i];
  assign rc_o = mem[rc_i];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem <= '{default: '0};
    else if (we_i) mem[ra_i] <= wd_i;
  end
endmodule

module simple_cpu_execunit
  import simple_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_i,
  input  logic [15:0] dmem_rdata_i,
  output logic [9:0]  pc_o,
  output logic [7:0]  dmem_addr_o,
  output logic        dmem_we_o,
  output logic [15:0] dmem_wdata_o
);
  logic [3:0] op, ra, rb, rc;
  logic [7:0] imm8;
  logic [15:0] ra_val, rb_val, rc_val, wdata;
  logic we;
  logic [9:0] pc_q, pc_d;
  assign op = instr_i[OP_MSB:OP_LSB];
  assign ra = instr_i[RA_MSB:RA_LSB];
  assign rb = instr_i[RB_MSB:RB_LSB];
  assign rc = instr_i[RC_MSB:RC_LSB];
  assign imm8 = instr_i[IMM_MSB:IMM_LSB];
  simple_cpu_regbank RegBank (
    .clk(clk), .rst(rst), .ra_i(ra), .rb_i(rb), .rc_i(rc),
    .we_i(we), .wd_i(wdata), .ra_o(ra_val), .rb_o(rb_val), .rc_o(rc_val)
  );
  always_comb begin
    we = 1'b1;
    wdata = '0;
    case (op)
      OP_LD:   wdata = dmem_rdata_i;
      OP_ADD:  wdata = rb_val + rc_val;
      OP_LDI:  wdata = {8'h00, imm8};
      OP_SUB:  wdata = rb_val - rc_val;
      OP_AND:  wdata = rb_val & rc_val;
      OP_OR:   wdata = rb_val | rc_val;
      OP_XOR:  wdata = rb_val ^ rc_val;
      default: we = 1'b0;
    endcase
  end
  // branch offsets are relative to the branch's own address, wrapping mod 1024
  assign pc_d = (op == OP_JMP || (op == OP_BZ && ra_val == 16'h0)) ? pc_q + sext_off(imm8) : pc_q + 10'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else pc_q <= pc_d;
  end
  assign pc_o = pc_q;
  assign dmem_addr_o = imm8;
  assign dmem_wdata_o = ra_val;
  // a store sampled while reset is low must not land
  assign dmem_we_o = (op == OP_ST) && rst;
endmodule

// File: rtl/simple_cpu_mem.sv
// simple_cpu_mem: word array with combinational read and clocked write, no reset
module simple_cpu_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_array [0:(1<<AW)-1];
  assign rdata_o = mem_array[addr_i];
  always_ff @(posedge clk) begin
    if (we_i) mem_array[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/simple_cpu.sv
// simple_cpu: single-cycle 16-bit load/store CPU with instruction and data memories
module simple_cpu (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pc
);
  logic [15:0] instr, dmem_rdata, dmem_wdata;
  logic [7:0] dmem_addr;
  logic dmem_we;
  simple_cpu_mem #(.AW(10)) instmem (
    .clk(clk), .we_i(1'b0), .addr_i(pc), .wdata_i(16'h0), .rdata_o(instr)
  );
  simple_cpu_mem #(.AW(8)) datamemory (
    .clk(clk), .we_i(dmem_we), .addr_i(dmem_addr), .wdata_i(dmem_wdata), .rdata_o(dmem_rdata)
  );
  simple_cpu_execunit execunit (
    .clk(clk), .rst(rst), .instr_i(instr), .dmem_rdata_i(dmem_rdata),
    .pc_o(pc), .dmem_addr_o(dmem_addr), .dmem_we_o(dmem_we), .dmem_wdata_o(dmem_wdata)
  );
endmodule

// File: tb/tb_simple_cpu.sv
// tb_simple_cpu: directed programs with hand-computed register, memory and pc values
module tb_simple_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [9:0] pc;
  int checks = 0;
  int failures = 0;
  logic [15:0] dm [0:255];
  simple_cpu dut (.clk(clk), .rst(rst), .pc(pc));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] ri(input logic [3:0] op, input logic [3:0] ra, input logic [7:0] imm);
    return {op, ra, imm};
  endfunction
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc};
  endfunction
  function automatic logic [15:0] rg(input int i);
    return dut.execunit.RegBank.mem[i];
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic start;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.instmem.mem_array[i] = 16'hF000;
  endtask
  initial begin
    int bad;
    logic [15:0] r0m;
    start;
    dut.instmem.mem_array[0] = ri(3, 1, 8'h02);
    dut.instmem.mem_array[1] = ri(3, 2, 8'h03);
    dut.instmem.mem_array[2] = rr(2, 3, 1, 2);
    dut.instmem.mem_array[3] = rr(6, 4, 1, 2);
    dut.instmem.mem_array[4] = rr(7, 5, 1, 2);
    dut.instmem.mem_array[5] = rr(8, 6, 1, 2);
    dut.instmem.mem_array[6] = rr(9, 7, 1, 2);
    dut.instmem.mem_array[7] = rr(2, 1, 1, 1);
    dut.instmem.mem_array[8] = 16'hA1FF;
    step(2);
    check("rst_pc", {6'd0, pc}, 16'h0);
    check("rst_r1", rg(1), 16'h0);
    rst = 1'b1;
    check("rel_pc", {6'd0, pc}, 16'h0);
    step(1);
    check("fetch_pc", {6'd0, pc}, 16'h1);
    check("fetch_r1", rg(1), 16'h0002);
    step(8);
    check("alu_pc", {6'd0, pc}, 16'd9);
    check("add_r3", rg(3), 16'h0005);
    check("sub_r4", rg(4), 16'hFFFF);
    check("and_r5", rg(5), 16'h0002);
    check("or_r6", rg(6), 16'h0003);
    check("xor_r7", rg(7), 16'h0001);
    check("raw_nop_r1", rg(1), 16'h0004);
    start;
    for (int i = 0; i < 256; i++) dm[i] = 16'($urandom);
    dm[3] = 16'hDEAD;
    dm[7] = 16'hBEEF;
    dm[9] = 16'h1234;
    for (int i = 0; i < 256; i++) dut.datamemory.mem_array[i] = dm[i];
    dut.instmem.mem_array[0] = ri(3, 0, 8'h63);
    dut.instmem.mem_array[1] = ri(1, 0, 8'd3);
    dut.instmem.mem_array[2] = ri(3, 1, 8'h01);
    dut.instmem.mem_array[3] = ri(0, 2, 8'd3);
    dut.instmem.mem_array[4] = rr(2, 3, 2, 1);
    dut.instmem.mem_array[5] = ri(1, 3, 8'd7);
    dut.instmem.mem_array[6] = ri(0, 4, 8'd7);
    rst = 1'b1;
    step(7);
    dm[3] = 16'h0063;
    dm[7] = 16'h0064;
    check("st_dm3", dut.datamemory.mem_array[3], 16'h0063);
    check("ld_r2", rg(2), 16'h0063);
    check("ld_add_r3", rg(3), 16'h0064);
    check("st_dm7", dut.datamemory.mem_array[7], 16'h0064);
    check("st_ld_fwd_r4", rg(4), 16'h0064);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dut.datamemory.mem_array[i] !== dm[i]) bad++;
    check("dmem_others", 16'(bad), 16'h0);
    start;
    dut.instmem.mem_array[0] = ri(3, 1, 8'h01);
    dut.instmem.mem_array[1] = ri(3, 2, 8'h00);
    dut.instmem.mem_array[2] = rr(6, 0, 2, 1);
    dut.instmem.mem_array[3] = rr(6, 0, 0, 1);
    dut.instmem.mem_array[11] = rr(2, 0, 0, 1);
    dut.instmem.mem_array[12] = ri(5, 2, 8'hFF);
    rst = 1'b1;
    step(11);
    check("loop_entry_pc", {6'd0, pc}, 16'd11);
    check("loop_entry_r0", rg(0), 16'hFFFE);
    r0m = 16'hFFFE;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k % 2 == 1) r0m = r0m + 16'h1;
      check($sformatf("loop_pc_%0d", k), {6'd0, pc}, (k % 2 == 1) ? 16'd12 : 16'd11);
      check($sformatf("loop_r0_%0d", k), rg(0), r0m);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_pc", {6'd0, pc}, 16'h0);
    check("midrst_r0", rg(0), 16'h0);
    check("midrst_r1", rg(1), 16'h0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rg(i) !== 16'h0) bad++;
    check("midrst_regs", 16'(bad), 16'h0);
    check("midrst_dm3", dut.datamemory.mem_array[3], 16'h0063);
    start;
    dut.instmem.mem_array[0] = ri(3, 5, 8'h77);
    dut.instmem.mem_array[1] = ri(1, 5, 8'd9);
    rst = 1'b1;
    step(1);
    check("abort_pre_pc", {6'd0, pc}, 16'h1);
    rst = 1'b0;
    step(1);
    check("abort_dm9", dut.datamemory.mem_array[9], 16'h1234);
    check("abort_pc", {6'd0, pc}, 16'h0);
    rst = 1'b1;
    step(2);
    check("restart_pc", {6'd0, pc}, 16'h2);
    check("restart_dm9", dut.datamemory.mem_array[9], 16'h0077);
    start;
    dut.instmem.mem_array[0] = ri(3, 1, 8'h05);
    dut.instmem.mem_array[1] = ri(5, 1, 8'h04);
    dut.instmem.mem_array[2] = ri(4, 0, 8'h09);
    dut.instmem.mem_array[11] = ri(4, 0, 8'hFB);
    dut.instmem.mem_array[6] = ri(4, 0, 8'hF9);
    dut.instmem.mem_array[1023] = ri(4, 0, 8'h01);
    rst = 1'b1;
    step(2);
    check("bz_not_taken_pc", {6'd0, pc}, 16'd2);
    step(1);
    check("jmp_fwd_pc", {6'd0, pc}, 16'd11);
    step(1);
    check("jmp_back_pc", {6'd0, pc}, 16'd6);
    step(1);
    check("jmp_wrap_low_pc", {6'd0, pc}, 16'd1023);
    step(1);
    check("jmp_wrap_high_pc", {6'd0, pc}, 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
